nice_seq_iterator: RTL and testbench
====================================

# nice_seq_iterator

Hardware iterator stage that walks an indexed sequential store (a deque/ring buffer exposing a `get(i)` read port) and streams its elements out one at a time on a valid/ready interface. It sits directly downstream of the storage block: it issues indexed reads, absorbs the one-cycle read latency, and presents elements in order with a `last` marker. This is the RTL counterpart of `sequential_iterator` over a `sequential_collection`.

## Interface
Parameters:
- `DATA_W`, 32, element width.
- `IDX_W`, 8, index width; store depth is 2**IDX_W.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  iteration request.
- `start_ready`  out  1  high only in IDLE.
- `start_idx`  in  IDX_W  first index.
- `start_len`  in  IDX_W+1  element count, 0..2**IDX_W.
- `start_rev`  in  1  direction; present only with `NICE_ITER_REVERSE_EN`.
- `rd_en`  out  1  read strobe to the store.
- `rd_idx`  out  IDX_W  read index.
- `rd_data`  in  DATA_W  read result, valid exactly one cycle after `rd_en`.
- `out_valid`  out  1  element available.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  DATA_W  element.
- `out_last`  out  1  qualifies the final element.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at iteration end.

## Operation
- States: IDLE, RUN (issuing reads), DRAIN (all reads issued, buffer not empty).
- IDLE -> RUN on `start_valid && start_ready` with len>0. Latches idx/len. Sets `remaining_rd = len` and `remaining_out = len`.
- IDLE with len==0: request accepted, no reads, no output. `done` pulses the next cycle. State stays IDLE.
- RUN: issue `rd_en` when `occupancy + inflight < 2` (2-entry output buffer, credit-based). Each issue advances idx by +1 (or -1 in reverse), modulo 2**IDX_W, with natural wrap: 255+1 -> 0 and 0-1 -> 255. Each issue decrements `remaining_rd`. RUN -> DRAIN when the last read issues.
- Capture: the cycle after `rd_en`, `rd_data` is pushed into the buffer unconditionally. Credits guarantee there is space.
- Output: buffer head drives `out_data`. `out_last = out_valid && remaining_out==1`.
- Each `out_valid && out_ready` pops and decrements `remaining_out`.
- DRAIN -> IDLE and `done` pulses in the same cycle the last element handshakes.
- Push and pop in the same cycle are allowed. Occupancy is unchanged.
- `out_data` is held stable while `out_valid && !out_ready`.
- `start_valid` outside IDLE is ignored (`start_ready` is 0).
- Reset values: `start_ready` = 1. `rd_en`, `out_valid`, `out_last`, `busy`, `done` = 0. `rd_idx`, `out_data` = 0.
- Reset mid-operation: all state clears. A `rd_data` return in the cycle after reset is discarded.

## Timing
- Start handshake at cycle T.
- First `rd_en` at T+1.
- Data captured at the edge ending T+2.
- First `out_valid` at T+3.
- Throughput is 1 element/cycle while `out_ready` stays high.
- A `len`=N iteration with no backpressure ends with the last handshake and `done` at T+N+2.
- Next `start_ready` is at T+N+3.
- Under backpressure, at most 2 reads are outstanding or buffered. `rd_en` stalls within the same cycle the credit condition fails.

## Configuration
- `NICE_ITER_REVERSE_EN` defined: `start_rev` port exists. rev=1 decrements the index per read, from `start_idx` down to `start_idx-len+1` mod depth.
- Not defined: port is absent and iteration is forward only. There is no direction register.

## Structure
- Package `nice_iter_pkg` holds:
  - `iter_state_e` enum {IDLE, RUN, DRAIN};
  - `localparam` helpers for depth (2**IDX_W);
  - the `idx_step` function (wrap-around add/subtract).
- Sub-module `nice_iter_fifo2`: 2-entry registered FIFO with push/pop/count, parameterised on `DATA_W`. It holds the output buffer.
- Top contains the FSM, counters and credit logic.

## Test plan
- **Basic:** store[i]=i+0x100, start idx=3 len=4, `out_ready`=1.
  - rd_idx 3,4,5,6 at T+1..T+4.
  - out_data 0x103..0x106 at T+3..T+6.
  - `out_last` and `done` at T+6.
- **Wrap:** IDX_W=8, idx=254 len=4.
  - rd_idx 254,255,0,1; outputs in that order.
- **Backpressure:** len=6, `out_ready` toggles 1,0,0,1,…
  - No element dropped or duplicated.
  - `out_data` stable while stalled.
  - Never more than 2 reads outstanding or buffered.
- **Zero length:** len=0.
  - No `rd_en`, no `out_valid`.
  - `done` at T+1; `start_ready` stays 1.
- **Reset mid-run:** `rst` at T+4 of a len=8 run.
  - Next cycle: all outputs at reset values, `start_ready`=1.
  - Stale `rd_data` is not emitted.
- **Reverse** (macro defined): idx=1 len=3 rev=1.
  - rd_idx 1,0,255; `out_last` on the third element.

Source files
------------

// File: rtl/nice_iter_pkg.sv
// Shared types and helpers for the nice_seq_iterator slice: FSM state encoding,
// default sizes and the wrap-around index step.
package nice_iter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } iter_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_IDX_W  = 8;
    localparam int DEF_DEPTH  = 1 << DEF_IDX_W;
    localparam int MAX_IDX_W  = 16;

    function automatic int depth_of(input int unsigned idx_w);
        return 1 << idx_w;
    endfunction

    // Next index one step forward or backward, wrapped modulo 2**idx_w.
    function automatic logic [MAX_IDX_W-1:0] idx_step(
        input logic [MAX_IDX_W-1:0] idx,
        input logic                 rev,
        input int unsigned          idx_w
    );
        logic [MAX_IDX_W-1:0] nxt;
        logic [MAX_IDX_W-1:0] mask;
        nxt  = rev ? (idx - MAX_IDX_W'(1)) : (idx + MAX_IDX_W'(1));
        mask = MAX_IDX_W'(depth_of(idx_w) - 1);
        return nxt & mask;
    endfunction

endpackage

// File: rtl/nice_iter_fifo2.sv
// Two-entry registered FIFO holding elements between the store read port and
// the consumer; head entry is presented directly as pop data.
module nice_iter_fifo2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full buffer is only legal when it coincides with a pop.
    assign do_pop    = pop && (count != 2'd0);
    assign do_push   = push && ((count != 2'd2) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nice_seq_iterator.sv
// Iterator stage streaming elements of an indexed store out on valid/ready.
// Optional reverse walking is enabled by defining NICE_ITER_REVERSE_EN.
module nice_seq_iterator
    import nice_iter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [IDX_W-1:0]  start_idx,
    input  logic [IDX_W:0]    start_len,
`ifdef NICE_ITER_REVERSE_EN
    input  logic              start_rev,
`endif
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    iter_state_e       state_q;
    iter_state_e       state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_next;
    logic [IDX_W:0]    rem_rd_q;
    logic [IDX_W:0]    rem_out_q;
    logic              inflight_q;
    logic              zero_done_q;
    logic              step_rev;
    logic              start_fire;
    logic              pop;
    logic              last_rd;
    logic              last_pop;
    logic [1:0]        fifo_count;
    logic [2:0]        credit_used;
    logic              issue_ok;

`ifdef NICE_ITER_REVERSE_EN
    logic dir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else if (start_fire && (start_len != '0)) begin
            dir_q <= start_rev;
        end
    end

    assign step_rev = dir_q;
`else
    assign step_rev = 1'b0;
`endif

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign start_fire  = start_valid && start_ready;
    assign idx_next    = IDX_W'(idx_step(MAX_IDX_W'(idx_q), step_rev, IDX_W));

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_last  = out_valid && (rem_out_q == (IDX_W+1)'(1));

    // Credits count buffered plus in-flight elements; a same-cycle pop frees
    // one, which is what sustains one read per cycle without backpressure.
    assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue_ok    = (credit_used < 3'd2);

    assign rd_en    = (state_q == RUN) && issue_ok;
    assign rd_idx   = idx_q;
    assign last_rd  = rd_en && (rem_rd_q == (IDX_W+1)'(1));
    assign last_pop = pop && (rem_out_q == (IDX_W+1)'(1));

    always_comb begin
        state_d = state_q;
        done    = zero_done_q;
        case (state_q)
            IDLE: begin
                if (start_fire && (start_len != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_rd) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A read issued in the reset cycle returns afterwards; clearing the
    // in-flight flag is what keeps that stale word out of the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rem_rd_q    <= '0;
            rem_out_q   <= '0;
            inflight_q  <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= rd_en;
            zero_done_q <= start_fire && (start_len == '0);
            if (start_fire && (start_len != '0)) begin
                idx_q     <= start_idx;
                rem_rd_q  <= start_len;
                rem_out_q <= start_len;
            end else begin
                if (rd_en) begin
                    idx_q    <= idx_next;
                    rem_rd_q <= rem_rd_q - (IDX_W+1)'(1);
                end
                if (pop) begin
                    rem_out_q <= rem_out_q - (IDX_W+1)'(1);
                end
            end
        end
    end

    nice_iter_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (rd_data),
        .pop       (pop),
        .head_data (out_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_nice_seq_iterator.sv
// Directed bench for nice_seq_iterator with a behavioural store (store[i] = i + 0x100).
// Reverse scenario is compiled in only when NICE_ITER_REVERSE_EN is defined.
module tb_nice_seq_iterator;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [7:0]  start_idx;
    logic [8:0]  start_len;
`ifdef NICE_ITER_REVERSE_EN
    logic        start_rev;
`endif
    logic        rd_en;
    logic [7:0]  rd_idx;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] store_mem [256];
    int          vectors;
    int          misses;

    nice_seq_iterator #(
        .DATA_W (32),
        .IDX_W  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_idx   (start_idx),
        .start_len   (start_len),
`ifdef NICE_ITER_REVERSE_EN
        .start_rev   (start_rev),
`endif
        .rd_en       (rd_en),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Store with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= store_mem[rd_idx];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) next_cycle();
        #1;
        vectors++;
        if ({start_ready, rd_en, out_valid, out_last, busy, done} !== 6'b100000) begin
            misses++;
            $display("[TB] FAIL reset_ctrl got %b want 100000",
                     {start_ready, rd_en, out_valid, out_last, busy, done});
        end
        vectors++;
        if ({rd_idx, out_data} !== 40'h0) begin
            misses++;
            $display("[TB] FAIL reset_data got rd_idx=%h out_data=%h want 0/0", rd_idx, out_data);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_basic();
        bit e_rd, e_val, e_last, e_busy;
        start_valid = 1'b1; start_idx = 8'd3; start_len = 9'd4; out_ready = 1'b1;
        #1;
        vectors++;
        if (start_ready !== 1'b1) begin
            misses++;
            $display("[TB] FAIL basic_start_ready got %b want 1", start_ready);
        end
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            start_valid = 1'b0;
            #1;
            e_rd = (k <= 4); e_val = (k >= 3 && k <= 6); e_last = (k == 6); e_busy = (k <= 6);
            vectors++;
            if ({rd_en, out_valid, out_last, done, busy, start_ready} !==
                {e_rd, e_val, e_last, e_last, e_busy, !e_busy}) begin
                misses++;
                $display("[TB] FAIL basic_ctrl T+%0d got %b want %b", k,
                         {rd_en, out_valid, out_last, done, busy, start_ready},
                         {e_rd, e_val, e_last, e_last, e_busy, !e_busy});
            end
            if (e_rd) begin
                vectors++;
                if (rd_idx !== 8'(3 + k - 1)) begin
                    misses++;
                    $display("[TB] FAIL basic_rd_idx T+%0d got %0d want %0d", k, rd_idx, 3 + k - 1);
                end
            end
            if (e_val) begin
                vectors++;
                if (out_data !== 32'(32'h103 + k - 3)) begin
                    misses++;
                    $display("[TB] FAIL basic_out_data T+%0d got %h want %h", k, out_data,
                             32'(32'h103 + k - 3));
                end
            end
        end
        next_cycle();
    endtask

    task automatic test_wrap();
        logic [7:0]  e_idx;
        logic [31:0] e_data;
        start_valid = 1'b1; start_idx = 8'd254; start_len = 9'd4; out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            start_valid = 1'b0;
            #1;
            if (k <= 4) begin
                e_idx = 8'(254 + k - 1);
                vectors++;
                if (rd_en !== 1'b1 || rd_idx !== e_idx) begin
                    misses++;
                    $display("[TB] FAIL wrap_rd T+%0d got en=%b idx=%0d want en=1 idx=%0d",
                             k, rd_en, rd_idx, e_idx);
                end
            end
            if (k >= 3 && k <= 6) begin
                e_data = 32'h100 + {24'h0, 8'(254 + k - 3)};
                vectors++;
                if (out_valid !== 1'b1 || out_data !== e_data || out_last !== (k == 6)) begin
                    misses++;
                    $display("[TB] FAIL wrap_out T+%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             k, out_valid, out_data, out_last, e_data, (k == 6));
                end
            end
            if (k == 7) begin
                vectors++;
                if (start_ready !== 1'b1 || out_valid !== 1'b0) begin
                    misses++;
                    $display("[TB] FAIL wrap_end got ready=%b valid=%b want 1/0", start_ready, out_valid);
                end
            end
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [3:0]  pat;
        logic [31:0] held;
        bit          holding;
        bit          finished;
        int          got;
        int          issued;
        int          popped;
        pat = 4'b1001; holding = 0; finished = 0; got = 0; issued = 0; popped = 0; held = '0;
        start_valid = 1'b1; start_idx = 8'd10; start_len = 9'd6; out_ready = 1'b1;
        for (int c = 0; c < 60 && !finished; c++) begin
            next_cycle();
            start_valid = 1'b0;
            out_ready = pat[c % 4];
            #1;
            if (holding) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    misses++;
                    $display("[TB] FAIL bp_stable cyc %0d got v=%b d=%h want v=1 d=%h",
                             c, out_valid, out_data, held);
                end
            end
            if (rd_en) issued++;
            if (out_valid && out_ready) begin
                vectors++;
                if (out_data !== 32'h100 + 32'(10 + got) || out_last !== (got == 5) ||
                    done !== (got == 5)) begin
                    misses++;
                    $display("[TB] FAIL bp_elem %0d got d=%h l=%b done=%b want d=%h l=%b done=%b",
                             got, out_data, out_last, done, 32'h100 + 32'(10 + got),
                             (got == 5), (got == 5));
                end
                got++;
                popped++;
                if (got == 6) finished = 1;
            end
            vectors++;
            if (issued - popped > 2) begin
                misses++;
                $display("[TB] FAIL bp_credit cyc %0d got outstanding=%0d want <=2", c, issued - popped);
            end
            holding = out_valid && !out_ready;
            held = out_data;
        end
        vectors++;
        if (!finished) begin
            misses++;
            $display("[TB] FAIL bp_timeout got %0d elements want 6", got);
        end
        next_cycle();
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || issued !== 6) begin
            misses++;
            $display("[TB] FAIL bp_after got valid=%b busy=%b reads=%0d want 0/0/6",
                     out_valid, busy, issued);
        end
        out_ready = 1'b1;
        next_cycle();
    endtask

    task automatic test_zero_length();
        start_valid = 1'b1; start_idx = 8'd40; start_len = 9'd0; out_ready = 1'b1;
        #1;
        vectors++;
        if (start_ready !== 1'b1 || rd_en !== 1'b0) begin
            misses++;
            $display("[TB] FAIL zero_T got ready=%b rd_en=%b want 1/0", start_ready, rd_en);
        end
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            start_valid = 1'b0;
            #1;
            vectors++;
            if ({done, start_ready, rd_en, out_valid, busy} !== {(k == 1), 1'b1, 1'b0, 1'b0, 1'b0}) begin
                misses++;
                $display("[TB] FAIL zero_T+%0d got %b want %b", k,
                         {done, start_ready, rd_en, out_valid, busy},
                         {(k == 1), 1'b1, 1'b0, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_reset_mid_run();
        start_valid = 1'b1; start_idx = 8'd20; start_len = 9'd8; out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            start_valid = 1'b0;
        end
        next_cycle();
        rst = 1'b1;
        #1;
        vectors++;
        if (rd_en !== 1'b1 || out_valid !== 1'b1) begin
            misses++;
            $display("[TB] FAIL rst_mid_T+4 got rd_en=%b valid=%b want 1/1", rd_en, out_valid);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        vectors++;
        if ({start_ready, rd_en, out_valid, out_last, busy, done} !== 6'b100000 ||
            rd_idx !== 8'd0 || out_data !== 32'd0) begin
            misses++;
            $display("[TB] FAIL rst_mid_T+5 got %b idx=%h d=%h want 100000 idx=0 d=0",
                     {start_ready, rd_en, out_valid, out_last, busy, done}, rd_idx, out_data);
        end
        for (int k = 6; k <= 7; k++) begin
            next_cycle();
            #1;
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                misses++;
                $display("[TB] FAIL rst_mid_stale T+%0d got valid=%b busy=%b want 0/0", k, out_valid, busy);
            end
        end
    endtask

`ifdef NICE_ITER_REVERSE_EN
    task automatic test_reverse();
        logic [7:0]  e_idx;
        logic [31:0] e_data;
        start_valid = 1'b1; start_idx = 8'd1; start_len = 9'd3; start_rev = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            start_valid = 1'b0;
            start_rev = 1'b0;
            #1;
            if (k <= 3) begin
                e_idx = 8'(1 - (k - 1));
                vectors++;
                if (rd_en !== 1'b1 || rd_idx !== e_idx) begin
                    misses++;
                    $display("[TB] FAIL rev_rd T+%0d got en=%b idx=%0d want en=1 idx=%0d",
                             k, rd_en, rd_idx, e_idx);
                end
            end
            if (k >= 3 && k <= 5) begin
                e_data = 32'h100 + {24'h0, 8'(1 - (k - 3))};
                vectors++;
                if (out_valid !== 1'b1 || out_data !== e_data || out_last !== (k == 5) ||
                    done !== (k == 5)) begin
                    misses++;
                    $display("[TB] FAIL rev_out T+%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             k, out_valid, out_data, out_last, e_data, (k == 5));
                end
            end
        end
        next_cycle();
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            store_mem[i] = 32'h100 + 32'(i);
        end
        vectors = 0;
        misses = 0;
        rst = 1'b1;
        start_valid = 1'b0;
        start_idx = '0;
        start_len = '0;
`ifdef NICE_ITER_REVERSE_EN
        start_rev = 1'b0;
`endif
        out_ready = 1'b0;
        rd_data = '0;

        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_reset_mid_run();
`ifdef NICE_ITER_REVERSE_EN
        test_reverse();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
